// File: rtl/ct_mat_pkg.sv
// Shared types for the pipe8 matrix issue path: unit encoding, meta widths and the
// FIFO entry layout carried from dispatch to the RF stage.
package ct_mat_pkg;

  typedef enum logic [1:0] {
    UnitCfg = 2'd0,
    UnitAlu = 2'd1,
    UnitLsu = 2'd2
  } mat_unit_e;

  localparam int unsigned AluMetaW = 31;
  localparam int unsigned LsuMetaW = 16;
  localparam int unsigned CfgMetaW = 4;

  typedef struct packed {
    mat_unit_e             unit;
    logic [6:0]            iid;
    logic [AluMetaW-1:0]   meta;
    logic [63:0]           src0;
    logic                  src0_vld;
    logic [63:0]           src1;
    logic                  src1_vld;
    logic                  dst_vld;
    logic [6:0]            dst_preg;
  } mat_issue_entry_t;

endpackage

// File: rtl/ct_mat_issue_fifo.sv
// In-order synchronous FIFO of matrix issue entries with a flush that empties it.
// Pointers carry an extra wrap bit so full/empty fall out of a plain compare.
module ct_mat_issue_fifo
  import ct_mat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  mat_issue_entry_t       wdata,
  input  logic                   pop,
  output mat_issue_entry_t       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam logic [Aw:0] PtrOne = (Aw + 1)'(1);

  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  mat_issue_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: nothing reads it until a pointer says it is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[Aw-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ct_idu_mat_pipe8_issue.sv
// IDU pipe8 matrix issue stage: buffers dispatched matrix ops in order, issues one per
// cycle under an in-flight credit limit and drives the registered RF-stage interface.
module ct_idu_mat_pipe8_issue
  import ct_mat_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                             forever_cpuclk,
  input  logic                             cpurst,
  input  logic                             rtu_yy_xx_flush,
  input  logic                             dis_mat_pipe8_vld,
  output logic                             dis_mat_pipe8_ready,
  input  logic [1:0]                       dis_mat_pipe8_type,
  input  logic [6:0]                       dis_mat_pipe8_iid,
  input  logic [30:0]                      dis_mat_pipe8_meta,
  input  logic [63:0]                      dis_mat_pipe8_src0,
  input  logic                             dis_mat_pipe8_src0_vld,
  input  logic [63:0]                      dis_mat_pipe8_src1,
  input  logic                             dis_mat_pipe8_src1_vld,
  input  logic                             dis_mat_pipe8_dst_vld,
  input  logic [6:0]                       dis_mat_pipe8_dst_preg,
  output logic [6:0]                       idu_mat_rf_pipe8_iid,
  output logic                             idu_mat_rf_cfg_sel,
  output logic                             idu_mat_rf_alu_sel,
  output logic                             idu_mat_rf_lsu_sel,
  output logic                             idu_mat_rf_cfg_gateclk_sel,
  output logic                             idu_mat_rf_alu_gateclk_sel,
  output logic                             idu_mat_rf_lsu_gateclk_sel,
  output logic [30:0]                      idu_mat_rf_pipe8_alu_meta,
  output logic [15:0]                      idu_mat_rf_pipe8_lsu_meta,
  output logic [3:0]                       idu_mat_rf_pipe8_cfg_meta,
  output logic                             idu_mat_rf_pipe8_alu_src0_vld,
  output logic [63:0]                      idu_mat_rf_pipe8_alu_src0,
  output logic [63:0]                      idu_mat_rf_pipe8_lsu_src0,
  output logic                             idu_mat_rf_pipe8_lsu_src1_vld,
  output logic [63:0]                      idu_mat_rf_pipe8_lsu_src1,
  output logic [63:0]                      idu_mat_rf_pipe8_cfg_src0,
  output logic                             idu_mat_rf_pipe8_cfg_dst_vld,
  output logic [6:0]                       idu_mat_rf_pipe8_cfg_dst_preg,
  input  logic                             mat_rtu_pipe8_cmplt,
  output logic [$clog2(MAX_OUTST+1)-1:0]   mat_outst_cnt
);

  localparam int unsigned FifoAw = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(MAX_OUTST + 1);
  localparam logic [FifoAw:0] FifoDepth = (FifoAw + 1)'(DEPTH);
  localparam logic [CntW-1:0] MaxCnt    = CntW'(MAX_OUTST);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  mat_issue_entry_t wr_entry, head;
  logic             fifo_empty;
  logic [FifoAw:0]  fifo_cnt;
  logic             push, issue;

  logic [CntW-1:0]  outst_cnt_q, outst_cnt_d;
  logic             cnt_inc, cnt_dec;

  // sel_q bit order: {lsu, alu, cfg}
  logic [2:0]       sel_q, sel_d;
  logic [6:0]       rf_iid_q;
  logic [30:0]      rf_meta_q;
  logic [63:0]      rf_src0_q, rf_src1_q;
  logic             rf_src0_vld_q, rf_src1_vld_q, rf_dst_vld_q;
  logic [6:0]       rf_dst_preg_q;

  assign wr_entry = '{
    unit:     mat_unit_e'(dis_mat_pipe8_type),
    iid:      dis_mat_pipe8_iid,
    meta:     dis_mat_pipe8_meta,
    src0:     dis_mat_pipe8_src0,
    src0_vld: dis_mat_pipe8_src0_vld,
    src1:     dis_mat_pipe8_src1,
    src1_vld: dis_mat_pipe8_src1_vld,
    dst_vld:  dis_mat_pipe8_dst_vld,
    dst_preg: dis_mat_pipe8_dst_preg
  };

  // Ready is from the registered count only; a same-cycle pop does not free a slot.
  assign dis_mat_pipe8_ready = (fifo_cnt < FifoDepth);
  assign push  = dis_mat_pipe8_vld && dis_mat_pipe8_ready && (dis_mat_pipe8_type != 2'd3)
                 && !rtu_yy_xx_flush;
  assign issue = !fifo_empty && (outst_cnt_q < MaxCnt) && !rtu_yy_xx_flush;

  ct_mat_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .flush (rtu_yy_xx_flush),
    .push  (push),
    .wdata (wr_entry),
    .pop   (issue),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Credit counter; completions at zero are ignored, flush overrides everything.
  assign cnt_inc = issue;
  assign cnt_dec = mat_rtu_pipe8_cmplt && (outst_cnt_q != '0);

  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (rtu_yy_xx_flush) begin
      outst_cnt_d = '0;
    end else if (cnt_inc && !cnt_dec) begin
      outst_cnt_d = outst_cnt_q + CntOne;
    end else if (cnt_dec && !cnt_inc) begin
      outst_cnt_d = outst_cnt_q - CntOne;
    end
  end

  always_comb begin
    sel_d = 3'b000;
    if (issue) begin
      unique case (head.unit)
        UnitCfg: sel_d = 3'b001;
        UnitAlu: sel_d = 3'b010;
        UnitLsu: sel_d = 3'b100;
        default: sel_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      outst_cnt_q <= '0;
      sel_q       <= '0;
    end else begin
      outst_cnt_q <= outst_cnt_d;
      sel_q       <= sel_d;
    end
  end

  // RF data holds its last value when nothing issues.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rf_iid_q      <= '0;
      rf_meta_q     <= '0;
      rf_src0_q     <= '0;
      rf_src0_vld_q <= 1'b0;
      rf_src1_q     <= '0;
      rf_src1_vld_q <= 1'b0;
      rf_dst_vld_q  <= 1'b0;
      rf_dst_preg_q <= '0;
    end else if (issue) begin
      rf_iid_q      <= head.iid;
      rf_meta_q     <= head.meta;
      rf_src0_q     <= head.src0;
      rf_src0_vld_q <= head.src0_vld;
      rf_src1_q     <= head.src1;
      rf_src1_vld_q <= head.src1_vld;
      rf_dst_vld_q  <= head.dst_vld;
      rf_dst_preg_q <= head.dst_preg;
    end
  end

  assign idu_mat_rf_cfg_sel         = sel_q[0];
  assign idu_mat_rf_alu_sel         = sel_q[1];
  assign idu_mat_rf_lsu_sel         = sel_q[2];
  assign idu_mat_rf_cfg_gateclk_sel = sel_q[0];
  assign idu_mat_rf_alu_gateclk_sel = sel_q[1];
  assign idu_mat_rf_lsu_gateclk_sel = sel_q[2];

  assign idu_mat_rf_pipe8_iid          = rf_iid_q;
  assign idu_mat_rf_pipe8_alu_meta     = rf_meta_q;
  assign idu_mat_rf_pipe8_lsu_meta     = rf_meta_q[LsuMetaW-1:0];
  assign idu_mat_rf_pipe8_cfg_meta     = rf_meta_q[CfgMetaW-1:0];
  assign idu_mat_rf_pipe8_alu_src0_vld = rf_src0_vld_q;
  assign idu_mat_rf_pipe8_alu_src0     = rf_src0_q;
  assign idu_mat_rf_pipe8_lsu_src0     = rf_src0_q;
  assign idu_mat_rf_pipe8_lsu_src1_vld = rf_src1_vld_q;
  assign idu_mat_rf_pipe8_lsu_src1     = rf_src1_q;
  assign idu_mat_rf_pipe8_cfg_src0     = rf_src0_q;
  assign idu_mat_rf_pipe8_cfg_dst_vld  = rf_dst_vld_q;
  assign idu_mat_rf_pipe8_cfg_dst_preg = rf_dst_preg_q;

  assign mat_outst_cnt = outst_cnt_q;

endmodule

// File: tb/tb_ct_idu_mat_pipe8_issue.sv
// Directed bench for the pipe8 matrix issue stage: a scoreboard of accepted dispatches
// is checked against every RF-stage issue, plus directed credit/flush/reset checks.
module tb_ct_idu_mat_pipe8_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic        ready;
  logic [1:0]  typ = '0;
  logic [6:0]  iid = '0;
  logic [30:0] meta = '0;
  logic [63:0] src0 = '0, src1 = '0;
  logic        src0_vld = 1'b0, src1_vld = 1'b0, dst_vld = 1'b0;
  logic [6:0]  dst_preg = '0;
  logic        cmplt = 1'b0;

  logic [6:0]  rf_iid;
  logic        cfg_sel, alu_sel, lsu_sel, cfg_gsel, alu_gsel, lsu_gsel;
  logic [30:0] alu_meta;
  logic [15:0] lsu_meta;
  logic [3:0]  cfg_meta;
  logic        alu_src0_vld, lsu_src1_vld, cfg_dst_vld;
  logic [63:0] alu_src0, lsu_src0, lsu_src1, cfg_src0;
  logic [6:0]  cfg_dst_preg;
  logic [3:0]  outst_cnt;

  ct_idu_mat_pipe8_issue #(
    .DEPTH     (4),
    .MAX_OUTST (8)
  ) dut (
    .forever_cpuclk                (clk),
    .cpurst                        (rst),
    .rtu_yy_xx_flush               (flush),
    .dis_mat_pipe8_vld             (vld),
    .dis_mat_pipe8_ready           (ready),
    .dis_mat_pipe8_type            (typ),
    .dis_mat_pipe8_iid             (iid),
    .dis_mat_pipe8_meta            (meta),
    .dis_mat_pipe8_src0            (src0),
    .dis_mat_pipe8_src0_vld        (src0_vld),
    .dis_mat_pipe8_src1            (src1),
    .dis_mat_pipe8_src1_vld        (src1_vld),
    .dis_mat_pipe8_dst_vld         (dst_vld),
    .dis_mat_pipe8_dst_preg        (dst_preg),
    .idu_mat_rf_pipe8_iid          (rf_iid),
    .idu_mat_rf_cfg_sel            (cfg_sel),
    .idu_mat_rf_alu_sel            (alu_sel),
    .idu_mat_rf_lsu_sel            (lsu_sel),
    .idu_mat_rf_cfg_gateclk_sel    (cfg_gsel),
    .idu_mat_rf_alu_gateclk_sel    (alu_gsel),
    .idu_mat_rf_lsu_gateclk_sel    (lsu_gsel),
    .idu_mat_rf_pipe8_alu_meta     (alu_meta),
    .idu_mat_rf_pipe8_lsu_meta     (lsu_meta),
    .idu_mat_rf_pipe8_cfg_meta     (cfg_meta),
    .idu_mat_rf_pipe8_alu_src0_vld (alu_src0_vld),
    .idu_mat_rf_pipe8_alu_src0     (alu_src0),
    .idu_mat_rf_pipe8_lsu_src0     (lsu_src0),
    .idu_mat_rf_pipe8_lsu_src1_vld (lsu_src1_vld),
    .idu_mat_rf_pipe8_lsu_src1     (lsu_src1),
    .idu_mat_rf_pipe8_cfg_src0     (cfg_src0),
    .idu_mat_rf_pipe8_cfg_dst_vld  (cfg_dst_vld),
    .idu_mat_rf_pipe8_cfg_dst_preg (cfg_dst_preg),
    .mat_rtu_pipe8_cmplt           (cmplt),
    .mat_outst_cnt                 (outst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [6:0]  iid;
    logic [30:0] meta;
    logic [63:0] src0;
    logic        src0_vld;
    logic [63:0] src1;
    logic        src1_vld;
    logic        dst_vld;
    logic [6:0]  dst_preg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one dispatch for one cycle; acc says whether the DUT must take it.
  task automatic drive(input logic [1:0] t, input logic [6:0] id, input logic [30:0] m,
                       input logic [63:0] s0, input logic [63:0] s1, input logic [6:0] preg,
                       input logic acc);
    exp_t e;
    typ = t; iid = id; meta = m; src0 = s0; src1 = s1; dst_preg = preg;
    src0_vld = id[0]; src1_vld = ~id[0]; dst_vld = id[1] | (t == 2'd0);
    vld = 1'b1;
    if (acc) begin
      e = '{typ: t, iid: id, meta: m, src0: s0, src0_vld: id[0], src1: s1,
            src1_vld: ~id[0], dst_vld: id[1] | (t == 2'd0), dst_preg: preg};
      sb.push_back(e);
    end
    step();
    vld = 1'b0;
  endtask

  // Every RF-stage issue must match the oldest accepted dispatch.
  always @(negedge clk) begin
    logic [2:0] sels;
    logic [2:0] exp_sel;
    sels = {lsu_sel, alu_sel, cfg_sel};
    if (!rst && sels != 3'b000) begin
      chk("gateclk_eq_sel", {lsu_gsel, alu_gsel, cfg_gsel}, sels);
      if (sb.size() == 0) begin
        chk("unexpected_issue", sels, 0);
      end else begin
        mon_e = sb.pop_front();
        exp_sel = (mon_e.typ == 2'd0) ? 3'b001 : (mon_e.typ == 2'd1) ? 3'b010 : 3'b100;
        chk("issue_sel", sels, exp_sel);
        chk("issue_iid", rf_iid, mon_e.iid);
        if (mon_e.typ == 2'd0) begin
          chk("cfg_meta", cfg_meta, mon_e.meta[3:0]);
          chk("cfg_src0", cfg_src0, mon_e.src0);
          chk("cfg_dst", {cfg_dst_vld, cfg_dst_preg}, {mon_e.dst_vld, mon_e.dst_preg});
        end else if (mon_e.typ == 2'd1) begin
          chk("alu_meta", alu_meta, mon_e.meta);
          chk("alu_src0", {alu_src0_vld, alu_src0}, {mon_e.src0_vld, mon_e.src0});
        end else begin
          chk("lsu_meta", lsu_meta, mon_e.meta[15:0]);
          chk("lsu_src0", lsu_src0, mon_e.src0);
          chk("lsu_src1", {lsu_src1_vld, lsu_src1}, {mon_e.src1_vld, mon_e.src1});
        end
      end
    end
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_sels", {lsu_sel, alu_sel, cfg_sel, lsu_gsel, alu_gsel, cfg_gsel}, 0);
    chk("rst_iid", rf_iid, 0);
    chk("rst_src0", alu_src0, 0);
    rst = 1'b0;
    step();

    // Single CFG: RF valid two cycles after the enqueue edge
    drive(2'd0, 7'd5, 31'h3, 64'h0010_0008_0004, 64'h0, 7'd12, 1'b1);
    chk("cfg_t1_sel", {lsu_sel, alu_sel, cfg_sel}, 3'b000);
    step();
    chk("cfg_t2_sel", {lsu_sel, alu_sel, cfg_sel}, 3'b001);
    chk("cfg_t2_gsel", cfg_gsel, 1);
    chk("cfg_t2_iid", rf_iid, 5);
    chk("cfg_t2_preg", cfg_dst_preg, 12);
    chk("cfg_t2_cnt", outst_cnt, 1);
    cmplt = 1'b1;
    step();
    cmplt = 1'b0;
    chk("cfg_ret_cnt", outst_cnt, 0);
    chk("rf_vld_clears", {lsu_sel, alu_sel, cfg_sel}, 3'b000);

    // Back-to-back CFG, ALU, LSU, ALU
    drive(2'd0, 7'd1, 31'h5, 64'h11, 64'h0, 7'd20, 1'b1);
    drive(2'd1, 7'd2, 31'h5A5A_1234, 64'hAAAA_0000_BBBB_0001, 64'h0, 7'd0, 1'b1);
    drive(2'd2, 7'd3, 31'h0000_BEEF, 64'h1000, 64'hCAFE_F00D_0000_0042, 7'd0, 1'b1);
    drive(2'd1, 7'd4, 31'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 7'd0, 1'b1);
    chk("b2b_lsu_third", {lsu_sel, alu_sel, cfg_sel}, 3'b100);
    step();
    chk("b2b_alu_fourth", {lsu_sel, alu_sel, cfg_sel, rf_iid}, {3'b010, 7'd4});
    chk("b2b_cnt", outst_cnt, 4);
    cmplt = 1'b1;
    repeat (4) step();
    cmplt = 1'b0;
    chk("b2b_drain_cnt", outst_cnt, 0);

    // Credit limit: eight issue, then DEPTH more fill the FIFO
    for (int i = 0; i < 8; i++)
      drive(i[0] ? 2'd2 : 2'd1, 7'(16 + i), 31'(i * 3 + 1), 64'(i * 64'h1111), 64'(~i), 7'd0,
            1'b1);
    step();
    chk("max_cnt", outst_cnt, 8);
    for (int i = 0; i < 4; i++)
      drive(i[0] ? 2'd2 : 2'd1, 7'(32 + i), 31'(i + 100), 64'(i + 64'h500), 64'(i), 7'd0, 1'b1);
    chk("full_ready", ready, 0);
    chk("full_cnt", outst_cnt, 8);
    chk("held_no_sel", {lsu_sel, alu_sel, cfg_sel}, 3'b000);
    drive(2'd1, 7'd99, 31'h1, 64'h1, 64'h1, 7'd0, 1'b0);
    chk("full_ready_still", ready, 0);
    cmplt = 1'b1;
    step();
    cmplt = 1'b0;
    chk("cmplt_at_max_cnt", outst_cnt, 7);
    chk("cmplt_at_max_no_issue", {lsu_sel, alu_sel, cfg_sel}, 3'b000);
    step();
    chk("reissue_cnt", outst_cnt, 8);
    chk("reissue_sel", {lsu_sel, alu_sel, cfg_sel}, 3'b010);
    chk("reissue_ready", ready, 1);

    // Flush with three queued, simultaneous cmplt and dispatch
    flush = 1'b1;
    cmplt = 1'b1;
    drive(2'd1, 7'd77, 31'h77, 64'h77, 64'h77, 7'd0, 1'b0);
    flush = 1'b0;
    cmplt = 1'b0;
    sb.delete();
    chk("flush_cnt", outst_cnt, 0);
    chk("flush_sels", {lsu_sel, alu_sel, cfg_sel}, 3'b000);
    chk("flush_ready", ready, 1);
    repeat (4) step();
    chk("flush_no_issue_cnt", outst_cnt, 0);

    // Simultaneous issue and cmplt at count 3, then cmplt at zero
    drive(2'd1, 7'd40, 31'h40, 64'h40, 64'h0, 7'd0, 1'b1);
    drive(2'd2, 7'd41, 31'h41, 64'h41, 64'h41, 7'd0, 1'b1);
    drive(2'd0, 7'd42, 31'h2, 64'h42, 64'h0, 7'd9, 1'b1);
    drive(2'd1, 7'd43, 31'h43, 64'h43, 64'h0, 7'd0, 1'b1);
    chk("pre_both_cnt", outst_cnt, 3);
    cmplt = 1'b1;
    step();
    cmplt = 1'b0;
    chk("both_cnt", outst_cnt, 3);
    cmplt = 1'b1;
    repeat (4) step();
    chk("drain_to_zero", outst_cnt, 0);
    step();
    cmplt = 1'b0;
    chk("cmplt_at_zero", outst_cnt, 0);

    // Illegal type is dropped
    drive(2'd3, 7'd60, 31'h60, 64'h60, 64'h60, 7'd0, 1'b0);
    repeat (3) step();
    chk("illegal_cnt", outst_cnt, 0);
    chk("illegal_sels", {lsu_sel, alu_sel, cfg_sel}, 3'b000);

    // Asynchronous reset while an issue is on the RF stage
    drive(2'd1, 7'd70, 31'h70, 64'hDEAD_BEEF, 64'h0, 7'd0, 1'b1);
    step();
    chk("pre_rst_sel", alu_sel, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_sels", {lsu_sel, alu_sel, cfg_sel, lsu_gsel, alu_gsel, cfg_gsel}, 0);
    chk("async_rst_cnt", outst_cnt, 0);
    chk("async_rst_iid", rf_iid, 0);
    chk("async_rst_ready", ready, 1);
    sb.delete();
    step();
    rst = 1'b0;
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ct_idu_mat_pipe8_issue.md
Name: ct_idu_mat_pipe8_issue

Overview:
IDU-side issue stage for the pipe8 matrix path. It drives the matrix subsystem's RF-stage interface: per-unit sel/gateclk_sel, meta, operands and IID. It buffers dispatched matrix instructions in an in-order FIFO and issues at most one per cycle. A credit counter, returned by the subsystem's pipe8 RTU completion, bounds the number of in-flight matrix instructions.

Parameters:
DEPTH, 4, issue FIFO entries (power of 2, >=2)
MAX_OUTST, 8, maximum issued-but-not-completed instructions (<=127)

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset
rtu_yy_xx_flush  in  1  pipeline flush
dis_mat_pipe8_vld  in  1  dispatch valid
dis_mat_pipe8_ready  out  1  FIFO can accept (registered-count based)
dis_mat_pipe8_type  in  2  0=CFG, 1=ALU, 2=LSU, 3=illegal (dropped, no enqueue)
dis_mat_pipe8_iid  in  7  instruction IID
dis_mat_pipe8_meta  in  31  union meta; ALU uses [30:0], LSU [15:0], CFG [3:0]
dis_mat_pipe8_src0  in  64  operand 0
dis_mat_pipe8_src0_vld  in  1  src0 valid (ALU)
dis_mat_pipe8_src1  in  64  operand 1 (LSU)
dis_mat_pipe8_src1_vld  in  1  src1 valid (LSU)
dis_mat_pipe8_dst_vld  in  1  CFG writes GPR
dis_mat_pipe8_dst_preg  in  7  CFG destination preg
idu_mat_rf_pipe8_iid  out  7  RF-stage IID
idu_mat_rf_{cfg,alu,lsu}_sel  out  1 each  unit select
idu_mat_rf_{cfg,alu,lsu}_gateclk_sel  out  1 each  unit clock-gate select
idu_mat_rf_pipe8_alu_meta  out  31;  idu_mat_rf_pipe8_lsu_meta  out  16;  idu_mat_rf_pipe8_cfg_meta  out  4
idu_mat_rf_pipe8_alu_src0_vld  out  1;  idu_mat_rf_pipe8_alu_src0  out  64
idu_mat_rf_pipe8_lsu_src0  out  64;  idu_mat_rf_pipe8_lsu_src1_vld  out  1;  idu_mat_rf_pipe8_lsu_src1  out  64
idu_mat_rf_pipe8_cfg_src0  out  64;  idu_mat_rf_pipe8_cfg_dst_vld  out  1;  idu_mat_rf_pipe8_cfg_dst_preg  out  7
mat_rtu_pipe8_cmplt  in  1  completion from matrix subsystem (credit return)
mat_outst_cnt  out  $clog2(MAX_OUTST+1)  in-flight count (debug/perf)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: FIFO empty, rd/wr pointers 0, RF valid 0, all sel/gateclk_sel 0, RF data/iid/meta 0, mat_outst_cnt 0, dis_mat_pipe8_ready 1.
- Enqueue when vld && ready && type!=3. ready = (fifo_cnt < DEPTH); no same-cycle dequeue bypass, so ready is 0 when full even if popping.
- No enqueue→issue bypass: entry written at t reaches head at t+1 and issues at t+1 at the earliest. RF outputs are valid at t+2.
- Issue at cycle t when !empty && mat_outst_cnt < MAX_OUTST && !flush. Head pops and RF registers load. In cycle t+1: rf_vld=1, and exactly one of the three sel signals is 1 per the stored type.
- gateclk_sel = the same registered value as sel.
- RF data outputs fan out one registered copy: cfg/alu/lsu src0 all = src0; metas are slices of the 31-bit meta.
- When no issue occurs, rf_vld clears next cycle. Data registers hold their last value.
- Strict in-order issue; no type reordering. A CFG is never overtaken, because later ALU/LSU instructions depend on the xmsize it writes.
- Credit counter: +1 on issue, -1 on cmplt, unchanged when both occur in the same cycle.
  - cmplt with count 0 is ignored (saturates at 0).
  - Issue with count==MAX_OUTST is blocked.
  - When count==MAX_OUTST and cmplt arrives, issue waits one cycle; the gate uses the registered count.
- Flush (rtu_yy_xx_flush=1), effective next cycle:
  - FIFO emptied; rf_vld and all sel cleared.
  - mat_outst_cnt = 0; flush wins over any simultaneous cmplt or issue.
  - A dispatch enqueue in the flush cycle is discarded.
  - Issue is suppressed in the flush cycle.
- Pointers are log2(DEPTH) bits plus a wrap bit; full/empty come from pointer compare. Wrap-around needs no special handling.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package ct_mat_pkg: mat_unit_e enum (CFG=0, ALU=1, LSU=2), meta width constants (31/16/4), and mat_issue_entry_t struct (type, iid, meta, src0, src0_vld, src1, src1_vld, dst_vld, dst_preg).
- Sub-module ct_mat_issue_fifo: parameterized sync FIFO of mat_issue_entry_t with flush input and count output.
- Credit counter and RF register stage stay in the top module.

Test Plan:
- Reset, then enqueue one CFG (iid=5, meta=4'h3, src0=64'h0010_0008_0004, dst_vld=1, preg=12) at t → t+2: cfg_sel=1, cfg_gateclk_sel=1, iid=5, cfg_dst_preg=12; other sels 0; mat_outst_cnt=1 at t+2.
- Back-to-back CFG, ALU, LSU, ALU (iid 1..4) → sels pulse in that exact order on four consecutive cycles; ready drops to 0 after DEPTH entries are held with no issue.
- MAX_OUTST=8: issue 8 with no cmplt → 9th held, count=8. Pulse one cmplt → count 7, 9th issues next cycle, count back to 8.
- Count=3 with simultaneous issue and cmplt → count stays 3. cmplt at count=0 → count stays 0.
- FIFO holds 3 entries, count=5, flush asserted with simultaneous cmplt and dispatch vld → next cycle FIFO empty, count=0, all sel=0, ready=1; dispatched entry never issues.
- Type=3 dispatch → not enqueued, no sel ever asserts. Reset asserted while rf_vld=1 → all sels drop immediately.
